// File: rtl/adpll_loop_ctrl.sv
// adpll_loop_ctrl: ADPLL digital loop controller.
// Synchronises the PFD flagU/flagD pulses into the reference clock domain. A
// binary search on the DCO code runs first, followed by +/-1 tracking. Lock
// is declared after a run of non-monotonic decisions and dropped after a run
// of same-direction decisions.
// Optional build macro LOOP_CTRL_RELOCK_EN: when defined, losing lock restarts
// the binary search from mid-scale. When undefined, tracking continues from
// the current code.
module adpll_loop_ctrl #(
  parameter int CODE_W     = 8,
  parameter int SETTLE_CYC = 4,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_RUN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flagU,
  input  logic              flagD,
  output logic [CODE_W-1:0] dco_code,
  output logic              upd,
  output logic              lock,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_TRACK  = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_t;

  localparam int SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int LOCK_W = $clog2(LOCK_CNT + 1);
  localparam int RUN_W  = $clog2(UNLOCK_RUN + 1);

  localparam logic [CODE_W-1:0] CODE_MID   = CODE_W'(1) << (CODE_W - 1);
  localparam logic [CODE_W-1:0] STEP_INIT  = CODE_W'(1) << (CODE_W - 2);
  localparam logic [CODE_W-1:0] STEP_LAST  = CODE_W'(1);
  localparam logic [SET_W-1:0]  SETTLE_LD  = SET_W'(SETTLE_CYC);
  localparam logic [LOCK_W-1:0] LOCK_LAST  = LOCK_W'(LOCK_CNT - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST   = RUN_W'(UNLOCK_RUN - 1);

  logic               r_fu_meta, r_fu, r_fd_meta, r_fd;
  state_t             r_state;
  dir_t               r_prev_dir;
  logic [CODE_W-1:0]  r_code;
  logic [CODE_W-1:0]  r_step;
  logic [SET_W-1:0]   r_settle;
  logic [LOCK_W-1:0]  r_lock_cnt;
  logic [RUN_W-1:0]   r_run_cnt;
  logic               r_upd;
  logic               r_lock;

  logic               w_up, w_dn, w_hold, w_same;
  logic [CODE_W-1:0]  w_delta;
  logic [CODE_W:0]    w_sum, w_dif;
  logic [CODE_W-1:0]  w_code_dec;

  // Two-flop synchronisers for the asynchronous PFD flags
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    if (!reset) begin
      r_fu_meta <= 1'b0;
      r_fu      <= 1'b0;
      r_fd_meta <= 1'b0;
      r_fd      <= 1'b0;
    end else begin
      r_fu_meta <= flagU;
      r_fu      <= r_fu_meta;
      r_fd_meta <= flagD;
      r_fd      <= r_fd_meta;
    end
  end

  assign w_up   = r_fu & ~r_fd;
  assign w_dn   = r_fd & ~r_fu;
  assign w_hold = ~(w_up | w_dn);
  assign w_same = (w_up && r_prev_dir == DIR_UP) || (w_dn && r_prev_dir == DIR_DN);

  // One extra bit of headroom exposes overflow/borrow so the code saturates.
  assign w_delta    = (r_state == S_SEARCH) ? r_step : STEP_LAST;
  assign w_sum      = {1'b0, r_code} + {1'b0, w_delta};
  assign w_dif      = {1'b0, r_code} - {1'b0, w_delta};
  assign w_code_dec = w_up ? (w_sum[CODE_W] ? {CODE_W{1'b1}} : w_sum[CODE_W-1:0]) :
                      w_dn ? (w_dif[CODE_W] ? {CODE_W{1'b0}} : w_dif[CODE_W-1:0]) :
                      r_code;

  // Loop FSM: settle timing, code updates, lock/unlock bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_prev_dir <= DIR_NONE;
      r_code     <= CODE_MID;
      r_step     <= STEP_INIT;
      r_settle   <= '0;
      r_lock_cnt <= '0;
      r_run_cnt  <= '0;
      r_upd      <= 1'b0;
      r_lock     <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      if (!en) begin
        // Disable wins over any decision; the code is frozen where it is.
        r_state    <= S_IDLE;
        r_prev_dir <= DIR_NONE;
        r_step     <= STEP_INIT;
        r_settle   <= '0;
        r_lock_cnt <= '0;
        r_run_cnt  <= '0;
        r_lock     <= 1'b0;
      end else if (r_state == S_IDLE) begin
        r_state  <= S_SEARCH;
        r_settle <= SETTLE_LD;
      end else if (r_settle != '0) begin
        r_settle <= r_settle - 1'b1;
      end else begin
        r_settle <= SETTLE_LD;
        r_code   <= w_code_dec;
        r_upd    <= (w_code_dec != r_code);
        if (w_up)      r_prev_dir <= DIR_UP;
        else if (w_dn) r_prev_dir <= DIR_DN;
        case (r_state)
          S_SEARCH: begin
            r_step <= r_step >> 1;
            if (w_hold || r_step == STEP_LAST) r_state <= S_TRACK;
          end
          S_TRACK: begin
            if (w_same) begin
              r_lock_cnt <= '0;
            end else begin
              r_lock_cnt <= r_lock_cnt + 1'b1;
              if (r_lock_cnt == LOCK_LAST) begin
                r_state <= S_LOCKED;
                r_lock  <= 1'b1;
              end
            end
          end
          S_LOCKED: begin
            if (!w_same) begin
              r_run_cnt <= '0;
            end else if (r_run_cnt != RUN_LAST) begin
              r_run_cnt <= r_run_cnt + 1'b1;
            end else begin
              r_run_cnt  <= '0;
              r_lock     <= 1'b0;
              r_lock_cnt <= '0;
`ifdef LOOP_CTRL_RELOCK_EN
              r_state    <= S_SEARCH;
              r_prev_dir <= DIR_NONE;
              r_code     <= CODE_MID;
              r_step     <= STEP_INIT;
              r_upd      <= (CODE_MID != r_code);
`else
              r_state    <= S_TRACK;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dco_code = r_code;
  assign upd      = r_upd;
  assign lock     = r_lock;
  assign state    = r_state;

endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// tb_adpll_loop_ctrl: directed bench for adpll_loop_ctrl (CODE_W=8, SETTLE_CYC=4,
// LOCK_CNT=16, UNLOCK_RUN=4). Expected {code,state,lock} triples are queued by
// the stimulus and popped by a monitor on every upd strobe. Steady-state and
// reset values are checked directly. Honours LOOP_CTRL_RELOCK_EN.
module tb_adpll_loop_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       flagU;
  logic       flagD;
  logic [7:0] dco_code;
  logic       upd;
  logic       lock;
  logic [1:0] state;

  typedef struct packed {
    logic [7:0] code;
    logic [1:0] st;
    logic       lk;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  adpll_loop_ctrl #(
    .CODE_W    (8),
    .SETTLE_CYC(4),
    .LOCK_CNT  (16),
    .UNLOCK_RUN(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .flagU   (flagU),
    .flagD   (flagD),
    .dco_code(dco_code),
    .upd     (upd),
    .lock    (lock),
    .state   (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n falling edges, then 1ns more so the monitor has already run.
  task automatic step_n(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] c, input logic [1:0] s, input logic l);
    exp_t e;
    e.code = c;
    e.st   = s;
    e.lk   = l;
    q.push_back(e);
  endtask

  // Wait (bounded) until the monitor has consumed every queued expectation.
  task automatic drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (q.size() != 0 && n < max_cyc) begin
      step_n(1);
      n++;
    end
    check(name, q.size(), 0);
    q.delete();
  endtask

  task automatic set_dir(input logic u, input logic d);
    flagU = u;
    flagD = d;
  endtask

  task automatic do_reset();
    en    = 1'b0;
    reset = 1'b0;
    step_n(2);
    reset = 1'b1;
    step_n(1);
  endtask

  // Monitor: every upd strobe must match the next queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && upd === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_upd: code=%0d state=%0d with nothing expected", dco_code, state);
        end else begin
          e = q.pop_front();
          check("upd_code", dco_code, e.code);
          check("upd_state", state, e.st);
          check("upd_lock", lock, e.lk);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] dn_codes [8];
    logic [7:0] up_codes [7];
    dn_codes = '{8'd64, 8'd32, 8'd16, 8'd8, 8'd4, 8'd2, 8'd1, 8'd0};
    up_codes = '{8'd192, 8'd224, 8'd240, 8'd248, 8'd252, 8'd254, 8'd255};

    set_dir(1'b0, 1'b0);
    en    = 1'b0;
    reset = 1'b0;
    step_n(2);
    check("rst_code", dco_code, 128);
    check("rst_lock", lock, 0);
    check("rst_state", state, 0);
    check("rst_upd", upd, 0);
    reset = 1'b1;
    step_n(1);

    // Downward search to 1, TRACK, then saturation at 0.
    set_dir(1'b0, 1'b1);
    step_n(3);
    for (int i = 0; i < 8; i++) push(dn_codes[i], (i >= 6) ? 2'd2 : 2'd1, 1'b0);
    en = 1'b1;
    drain("dn_search_drain", 100);
    step_n(12);
    check("dn_sat_code", dco_code, 0);
    check("dn_sat_state", state, 2);

    // Asynchronous reset in the middle of a run, checked between edges.
    #2;
    reset = 1'b0;
    #1;
    check("midrst_code", dco_code, 128);
    check("midrst_lock", lock, 0);
    check("midrst_state", state, 0);
    check("midrst_upd", upd, 0);
    en = 1'b0;
    step_n(2);
    reset = 1'b1;
    step_n(1);

    // Upward search to 255, then TRACK with UP held: saturated, no upd.
    set_dir(1'b1, 1'b0);
    step_n(3);
    for (int i = 0; i < 7; i++) push(up_codes[i], (i == 6) ? 2'd2 : 2'd1, 1'b0);
    en = 1'b1;
    drain("up_search_drain", 100);
    step_n(12);
    check("up_sat_code", dco_code, 255);
    check("up_sat_state", state, 2);
    check("up_sat_lock", lock, 0);

    // Alternating DN/UP in TRACK: lock on the 16th decision.
    for (int i = 1; i <= 16; i++) begin
      if (i % 2 == 1) set_dir(1'b0, 1'b1);
      else            set_dir(1'b1, 1'b0);
      push((i % 2 == 1) ? 8'd254 : 8'd255, (i == 16) ? 2'd3 : 2'd2, (i == 16));
      drain("alt_drain", 20);
    end

    // LOCKED with UP held (saturated at 255): unlock on the 4th decision.
`ifdef LOOP_CTRL_RELOCK_EN
    push(8'd128, 2'd1, 1'b0);
`endif
    step_n(16);
    check("locked3_lock", lock, 1);
    check("locked3_state", state, 3);
    check("locked3_code", dco_code, 255);
    step_n(6);
    check("unlock_lock", lock, 0);
`ifdef LOOP_CTRL_RELOCK_EN
    check("unlock_state", state, 1);
    check("unlock_code", dco_code, 128);
`else
    check("unlock_state", state, 2);
    check("unlock_code", dco_code, 255);
`endif
    check("unlock_drain", q.size(), 0);
    q.delete();
    do_reset();

    // en=0 in SEARCH at 224, then restart with full step from 224.
    set_dir(1'b1, 1'b0);
    step_n(3);
    push(8'd192, 2'd1, 1'b0);
    push(8'd224, 2'd1, 1'b0);
    en = 1'b1;
    drain("pre_dis_drain", 40);
    en = 1'b0;
    step_n(1);
    check("dis_state", state, 0);
    check("dis_code", dco_code, 224);
    check("dis_upd", upd, 0);
    check("dis_lock", lock, 0);
    set_dir(1'b0, 1'b1);
    step_n(3);
    push(8'd160, 2'd1, 1'b0);
    push(8'd128, 2'd1, 1'b0);
    push(8'd112, 2'd1, 1'b0);
    en = 1'b1;
    drain("restart_drain", 40);

    step_n(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
